instruction_cache: RTL
======================

// Module: instruction_cache
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the RV32I core fetch port and the
//  shared memory bus. Serves fetch hits with zero wait states. Refills misses with one bus read.
//  Reports bus errors as fetch access faults and flags fetch-address breakpoints to the core.
// PARAMETERS
//  INDEX_BITS      6             log2(line count); 64 lines x 32 bit. Tag = address[31:2+INDEX_BITS]
//  CACHEABLE_BASE  32'h0000_0000 start of the cacheable window
//  CACHEABLE_MASK  32'hF000_0000 address is cacheable iff (addr & MASK) == (BASE & MASK)
// PORTS
//  clk                    in   1   clock
//  rst                    in   1   reset, asynchronous, active-high
//  core_address           in   32  fetch address from core; held stable while core_busy=1
//  core_enable            in   1   fetch request
//  core_dataRead          out  32  instruction word; valid when core_enable && !core_busy
//  core_busy              out  1   fetch not yet satisfied
//  core_accessFault       out  1   bus error on this fetch; qualified like core_dataRead
//  core_addressBreakpoint out  1   fetch address matches breakpoint
//  cacheEnable            in   1   0: every fetch bypasses the array and goes to the bus
//  flush                  in   1   invalidate all lines (fence.i / management)
//  breakpointEnable       in   1   enable fetch breakpoint compare
//  breakpointAddress      in   32  breakpoint address; bits [1:0] ignored
//  mem_address            out  32  bus read address, always {core_address[31:2],2'b00}
//  mem_enable             out  1   bus cycle request; held until mem_ack or mem_error
//  mem_dataRead           in   32  bus read data, valid with mem_ack
//  mem_ack                in   1   bus read complete
//  mem_error              in   1   bus read failed; takes priority over mem_ack in the same cycle
// BEHAVIOUR
//  Storage: valid[2^INDEX_BITS], tag, and data arrays. Index = address[INDEX_BITS+1:2].
//  hit = cacheEnable && cacheable && valid[index] && tag[index]==core_address[31:2+INDEX_BITS].
//  FSM states: IDLE, REFILL, RESPOND, FAULT.
//   IDLE:
//    - core_enable && hit: core_busy=0; core_dataRead=data[index]; 0-cycle latency (combinational).
//    - core_enable && !hit: core_busy=1; next state REFILL.
//   REFILL:
//    - Outputs: mem_enable=1; core_busy=1.
//    - mem_error: next state FAULT.
//    - else mem_ack: capture mem_dataRead into the response register.
//      Cacheable && cacheEnable: also write the line, set valid. Next state RESPOND.
//   RESPOND: core_busy=0; core_dataRead=response register; core_accessFault=0. Next state IDLE.
//   FAULT: core_busy=0; core_accessFault=1; core_dataRead=0. Line not written. Next state IDLE.
//  Miss latency: N+1 cycles after the request, where N = bus cycles to mem_ack (min: ack in the
//   first REFILL cycle gives data in the 2nd cycle after the request).
//  core_enable dropped during REFILL:
//   - Bus cycle is not aborted; it runs to ack/error.
//   - Line is filled if cacheable. Next state IDLE, not RESPOND/FAULT; nothing is presented.
//  flush:
//   - Clears all valid bits at the next edge; takes effect from the next cycle.
//   - Flush in IDLE on a hit cycle: the current hit is still served.
//   - Flush during REFILL, or coincident with mem_ack: the refilled line is NOT marked valid.
//     The pending fetch still completes through RESPOND.
//  core_addressBreakpoint = core_enable && breakpointEnable && core_address[31:2]==breakpointAddress[31:2].
//   Combinational and independent of FSM state; the core samples it with the data.
//  Low address bits [1:0] are ignored; alignment checking belongs to the core.
//  core_enable=0: core_busy=0, core_accessFault=0, core_dataRead=0.
//  Reset (asynchronous, any state):
//   - All valid bits cleared; state=IDLE; response register=0.
//   - mem_enable drops immediately; an in-flight bus cycle is abandoned.
//   - Outputs after reset: core_busy=0, core_dataRead=0, core_accessFault=0, mem_enable=0.
// TESTING
//  1 Cold miss at 0x100, ack after 2 cycles with 0x00000013: busy for 3 cycles, data 0x00000013,
//    no fault. Refetch of 0x100: busy=0 same cycle, data 0x00000013, mem_enable stays 0.
//  2 Conflict: fetch 0x100 then 0x200 (same index, INDEX_BITS=6): both miss and refill.
//    Then 0x100 misses again.
//  3 mem_error on a fetch of 0x8000_0000: one cycle with busy=0, accessFault=1.
//    Refetch of the same address misses again (no line allocated).
//  4 cacheEnable=0, or an address outside the cacheable window: every fetch goes to the bus.
//    valid bits remain unchanged.
//  5 flush asserted in the ack cycle of a refill of 0x40: data is returned once.
//    Next fetch of 0x40 misses. Also check: flush in IDLE invalidates 0x100 filled earlier.
//  6 breakpointAddress=0x104, enable=1: breakpoint=1 only for fetches of 0x104..0x107.
//    Assert rst mid-REFILL: mem_enable=0 immediately; the following fetch misses.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped, one-word-per-line instruction cache for the RV32I fetch port.
// Fetch hits are answered combinationally from the arrays. A miss costs one
// bus read. Bus errors come back to the core as fetch access faults.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | serve hits combinationally, launch refill on a miss
// REFILL  | bus read outstanding, mem_enable held until ack/error
// RESPOND | present the captured bus word to the core for one cycle
// FAULT   | present an access fault (data 0) to the core for one cycle
module instruction_cache #(
  parameter int unsigned INDEX_BITS     = 6,
  parameter logic [31:0] CACHEABLE_BASE = 32'h0000_0000,
  parameter logic [31:0] CACHEABLE_MASK = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_address,
  input  logic        core_enable,
  output logic [31:0] core_dataRead,
  output logic        core_busy,
  output logic        core_accessFault,
  output logic        core_addressBreakpoint,
  input  logic        cacheEnable,
  input  logic        flush,
  input  logic        breakpointEnable,
  input  logic [31:0] breakpointAddress,
  output logic [31:0] mem_address,
  output logic        mem_enable,
  input  logic [31:0] mem_dataRead,
  input  logic        mem_ack,
  input  logic        mem_error
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESPOND, S_FAULT} state_e;

  state_e                 state_q, state_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [31:0]            data_q [LINES];
  logic [31:0]            resp_q, resp_d;
  logic                   flush_seen_q, flush_seen_d;

  logic [INDEX_BITS-1:0]  index;
  logic [TAG_W-1:0]       tag;
  logic                   cacheable;
  logic                   hit;
  logic                   bus_done_ok;
  logic                   fill_we;
  logic                   unused_lsbs;

  assign index       = core_address[INDEX_BITS+1:2];
  assign tag         = core_address[31:INDEX_BITS+2];
  assign cacheable   = (core_address & CACHEABLE_MASK) == (CACHEABLE_BASE & CACHEABLE_MASK);
  assign hit         = cacheEnable && cacheable && valid_q[index] && (tag_q[index] == tag);
  assign bus_done_ok = (state_q == S_REFILL) && mem_ack && !mem_error;
  // A flush anywhere in the refill window must keep the refilled line invalid.
  assign fill_we     = bus_done_ok && cacheable && cacheEnable && !flush && !flush_seen_q;
  assign mem_address = {core_address[31:2], 2'b00};
  assign core_addressBreakpoint = core_enable && breakpointEnable &&
                                  (core_address[31:2] == breakpointAddress[31:2]);
  assign unused_lsbs = ^{core_address[1:0], breakpointAddress[1:0]};

  // State, valid bits, response word and flush tracking; reset abandons any bus cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      resp_q       <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      resp_q       <= resp_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  // Tag and data arrays need no reset; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[index]  <= tag;
      data_q[index] <= mem_dataRead;
    end
  end

  // Datapath next-state: flush clears every valid bit and wins over a fill.
  always_comb begin
    valid_d      = valid_q;
    resp_d       = resp_q;
    flush_seen_d = (state_q == S_REFILL) && (flush || flush_seen_q);
    if (fill_we) valid_d[index] = 1'b1;
    if (flush)   valid_d = '0;
    if (bus_done_ok) resp_d = mem_dataRead;
  end

  // FSM next-state; a fetch abandoned by the core still completes its bus cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (core_enable && !hit) state_d = S_REFILL;
      S_REFILL: begin
        if (mem_error)    state_d = core_enable ? S_FAULT   : S_IDLE;
        else if (mem_ack) state_d = core_enable ? S_RESPOND : S_IDLE;
      end
      S_RESPOND: state_d = S_IDLE;
      S_FAULT:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs; everything toward the core is quiet while core_enable is low.
  always_comb begin
    core_dataRead    = '0;
    core_busy        = 1'b0;
    core_accessFault = 1'b0;
    mem_enable       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (core_enable) begin
          if (hit) core_dataRead = data_q[index];
          else     core_busy     = 1'b1;
        end
      end
      S_REFILL: begin
        mem_enable = 1'b1;
        core_busy  = core_enable;
      end
      S_RESPOND: if (core_enable) core_dataRead = resp_q;
      S_FAULT:   if (core_enable) core_accessFault = 1'b1;
      default: ;
    endcase
  end

endmodule
